// File: rtl/player_controller.sv
// player_controller
//   Sequencer and mode controller for the player physics datapath. Paces the
//   two-phase physics update (velocity phase game_tick[0], then position phase
//   game_tick[1]), synchronizes the raw buttons, issues a single-cycle
//   jump_pulse aligned with the velocity phase and tracks the player state.
//
//   Optional feature: define PLAYER_JUMP_BUFFER_EN to buffer an up press made
//   while airborne for JUMP_BUFFER_TICKS physics updates, so it chains into a
//   new jump right after landing.
//
// Parameters
//   FRAMES_PER_TICK   (1..15) frames per physics update
//   DEAD_HOLD_FRAMES  (1..63) frames after death during which up is ignored
//   JUMP_BUFFER_TICKS (1..7)  buffered request lifetime (PLAYER_JUMP_BUFFER_EN only)
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   frame_start  one-cycle pulse per video frame (synchronous)
//   button_up    raw jump button (asynchronous)
//   button_down  raw duck/fast-drop button (asynchronous)
//   collision    level: player overlaps an obstacle
//   jump_done    from physics, qualified by game_tick[1]
//   game_tick    one-hot phase enable: 01 velocity, 10 position, 00 idle
//   jump_pulse   one cycle, coincident with game_tick[0]
//   phys_down    down request to physics
//   state        0=IDLE 1=RUN 2=JUMP 3=DEAD (also the FSM debug view)
//   restart      one-cycle pulse on IDLE -> RUN
module player_controller #(
   parameter int FRAMES_PER_TICK   = 1,
   parameter int DEAD_HOLD_FRAMES  = 30,
   parameter int JUMP_BUFFER_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_start,
   input  logic       button_up,
   input  logic       button_down,
   input  logic       collision,
   input  logic       jump_done,
   output logic [1:0] game_tick,
   output logic       jump_pulse,
   output logic       phys_down,
   output logic [1:0] state,
   output logic       restart
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      JUMP = 2'd2,
      DEAD = 2'd3
   } state_t;

   localparam logic [3:0] TICK_LAST = 4'(FRAMES_PER_TICK - 1);
   localparam logic [5:0] DEAD_LAST = 6'(DEAD_HOLD_FRAMES);

   state_t     state_q, state_d;
   logic [3:0] frame_cnt, frame_cnt_d;
   logic [5:0] dead_cnt, dead_cnt_d;
   logic       jump_req, jump_req_d;
   logic [1:0] tick_d;
   logic       jump_pulse_d, phys_down_d, restart_d;

   logic       up_meta, up_sync, up_prev;
   logic       dn_meta, down_s;
   logic       up_rise;

   logic       active, die, issue, fire;

`ifdef PLAYER_JUMP_BUFFER_EN
   localparam logic [2:0] BUF_LOAD = 3'(JUMP_BUFFER_TICKS);
   logic [2:0] buf_cnt, buf_cnt_d;
`else
   logic [2:0] unused_buf_ticks;
   assign unused_buf_ticks = 3'(JUMP_BUFFER_TICKS);
`endif

   assign state = state_q;

   // Two-flop synchronizers; up_prev turns the synchronized level into an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         up_meta <= 1'b0;
         up_sync <= 1'b0;
         up_prev <= 1'b0;
         dn_meta <= 1'b0;
         down_s  <= 1'b0;
      end else begin
         up_meta <= button_up;
         up_sync <= up_meta;
         up_prev <= up_sync;
         dn_meta <= button_down;
         down_s  <= dn_meta;
      end
   end

   assign up_rise = up_sync & ~up_prev;

   // Pair protocol with physics: game_tick[0] is always followed by
   // game_tick[1] on the next cycle, and jump_done is only looked at while
   // game_tick[1] is high; there is no back-pressure from physics.
   assign active = (state_q == RUN) || (state_q == JUMP);
   // A pair whose phase 0 has fired is atomic, so death waits for phase 1.
   assign die    = active && collision && !game_tick[0];
   assign issue  = active && !die && frame_start && (game_tick == 2'b00) &&
                   (frame_cnt == TICK_LAST);
   // Down has priority in physics, so the jump waits while down is held.
   assign fire   = issue && (state_q == RUN) && jump_req && !down_s;

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt;
      dead_cnt_d   = dead_cnt;
      jump_req_d   = jump_req;
      tick_d       = 2'b00;
      jump_pulse_d = 1'b0;
      restart_d    = 1'b0;
      phys_down_d  = down_s && active;
`ifdef PLAYER_JUMP_BUFFER_EN
      buf_cnt_d    = buf_cnt;
`endif

      if (game_tick[0]) tick_d = 2'b10;
      if (issue)        tick_d = 2'b01;

      case (state_q)
         IDLE: begin
            frame_cnt_d = 4'd0;
            dead_cnt_d  = 6'd0;
            jump_req_d  = 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
            buf_cnt_d   = 3'd0;
`endif
            if (up_rise) begin
               state_d   = RUN;
               restart_d = 1'b1;
            end
         end

         RUN, JUMP: begin
            if (die) begin
               state_d     = DEAD;
               frame_cnt_d = 4'd0;
               dead_cnt_d  = 6'd0;
               jump_req_d  = 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
               buf_cnt_d   = 3'd0;
`endif
            end else begin
               if (frame_start)
                  frame_cnt_d = (frame_cnt == TICK_LAST) ? 4'd0 : frame_cnt + 4'd1;
`ifdef PLAYER_JUMP_BUFFER_EN
               // A buffered request ages once per velocity phase.
               if (game_tick[0] && (buf_cnt != 3'd0)) begin
                  buf_cnt_d = buf_cnt - 3'd1;
                  if (buf_cnt == 3'd1) jump_req_d = 1'b0;
               end
`endif
               if (state_q == RUN) begin
                  if (fire) begin
                     jump_pulse_d = 1'b1;
                     jump_req_d   = 1'b0;
                     state_d      = JUMP;
`ifdef PLAYER_JUMP_BUFFER_EN
                     buf_cnt_d    = 3'd0;
`endif
                  end else if (up_rise) begin
                     // A request made on the ground never expires.
                     jump_req_d = 1'b1;
`ifdef PLAYER_JUMP_BUFFER_EN
                     buf_cnt_d  = 3'd0;
`endif
                  end
               end else begin
                  if (game_tick[1] && jump_done) state_d = RUN;
`ifdef PLAYER_JUMP_BUFFER_EN
                  if (up_rise) begin
                     jump_req_d = 1'b1;
                     buf_cnt_d  = BUF_LOAD;
                  end
`endif
               end
            end
         end

         DEAD: begin
            frame_cnt_d = 4'd0;
            jump_req_d  = 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
            buf_cnt_d   = 3'd0;
`endif
            if (frame_start && (dead_cnt != DEAD_LAST)) dead_cnt_d = dead_cnt + 6'd1;
            if (up_rise && (dead_cnt == DEAD_LAST)) begin
               state_d    = IDLE;
               dead_cnt_d = 6'd0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         frame_cnt  <= 4'd0;
         dead_cnt   <= 6'd0;
         jump_req   <= 1'b0;
         game_tick  <= 2'b00;
         jump_pulse <= 1'b0;
         phys_down  <= 1'b0;
         restart    <= 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
         buf_cnt    <= 3'd0;
`endif
      end else begin
         state_q    <= state_d;
         frame_cnt  <= frame_cnt_d;
         dead_cnt   <= dead_cnt_d;
         jump_req   <= jump_req_d;
         game_tick  <= tick_d;
         jump_pulse <= jump_pulse_d;
         phys_down  <= phys_down_d;
         restart    <= restart_d;
`ifdef PLAYER_JUMP_BUFFER_EN
         buf_cnt    <= buf_cnt_d;
`endif
      end
   end

endmodule
